// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory responder and its storage array.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Word-address width for a given depth; a one-word memory still needs a one-bit index.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with per-byte write enables and a registered read port.
// Contents are deliberately never reset; only the read register holds state between accesses.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int ADDR_W      = addr_width(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Read data only changes when a read is requested, so it stays stable while a response is held.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[addr];
    end
  end

  // Byte-enabled write into the selected word, plus the read data register.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: accepts one request in IDLE, waits a fixed
// latency, then holds the response in RESP until the initiator consumes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int ADDR_W = addr_width(DEPTH_WORDS);
  // WAIT counts down from LATENCY-2 so that RESP begins LATENCY cycles after acceptance.
  localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

  state_t            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              err_d, err_q;
  logic              load_d, load_q;

  logic [29:0]       word_idx;
  logic              misaligned;
  logic              out_of_range;
  logic              req_err;
  logic              accept;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  assign word_idx     = req_addr[31:2];
  assign misaligned   = (req_addr[1:0] != 2'b00);
  assign out_of_range = ({2'b00, word_idx} >= 32'(DEPTH_WORDS));
  assign req_err      = misaligned | out_of_range;
  assign accept       = (state_q == IDLE) & req_valid;

  // Faulty requests never touch the array; loads capture the word on the acceptance edge.
  assign mem_we = accept & req_we & ~req_err;
  assign mem_re = accept & ~req_we & ~req_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .addr  (word_idx[ADDR_W-1:0]),
    .wdata (req_wdata),
    .be    (req_be),
    .rdata (mem_rdata)
  );

  // Next-state logic: accept in IDLE, count down in WAIT, hold in RESP until consumed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    load_d  = load_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d  = req_err;
          load_d = ~req_we & ~req_err;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and response-kind registers; reset drops any in-flight response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid & load_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench for dmem_responder: a LATENCY=2 instance for functional
// sequences and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        reset;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        req_valid_b, req_ready_b, req_we_b;
  logic [31:0] req_addr_b, req_wdata_b;
  logic [3:0]  req_be_b;
  logic        rsp_valid_b, rsp_ready_b, rsp_err_b;
  logic [31:0] rsp_rdata_b;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] model [DEPTH];
  logic [31:0] last_rdata;
  logic        last_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut_b (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid_b),
    .req_ready (req_ready_b),
    .req_we    (req_we_b),
    .req_addr  (req_addr_b),
    .req_wdata (req_wdata_b),
    .req_be    (req_be_b),
    .rsp_valid (rsp_valid_b),
    .rsp_ready (rsp_ready_b),
    .rsp_rdata (rsp_rdata_b),
    .rsp_err   (rsp_err_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one request on the LATENCY=2 instance, predict its response from the model,
  // optionally stall in RESP for 'stall' cycles, then consume it.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input int stall);
    logic [29:0] idx;
    logic        err;
    logic [32:0] exp;
    int          k;
    idx = addr[31:2];
    err = (addr[1:0] != 2'b00) || ({2'b00, idx} >= 32'(DEPTH));
    if (err) begin
      exp = {1'b1, 32'h0};
    end else if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model[idx[5:0]][8*i +: 8] = wdata[8*i +: 8];
      end
      exp = {1'b0, 32'h0};
    end else begin
      exp = {1'b0, model[idx[5:0]]};
    end
    exp_q.push_back(exp);

    checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'h0000_0004;
    req_wdata = 32'hFFFF_FFFF;
    req_be    = 4'hF;

    k = 1;
    while (!rsp_valid && k <= 20) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("rsp_latency", 32'(k), 32'(LAT));

    exp = exp_q.pop_front();
    if (rsp_valid) begin
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
      checkOutput("rsp_rdata", rsp_rdata, exp[31:0]);
      checkOutput("rsp_err", 32'(rsp_err), 32'(exp[32]));
      checkOutput("req_ready_in_resp", 32'(req_ready), 32'd0);
      for (int s = 0; s < stall; s++) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h0000_0010;
        req_wdata = 32'h0;
        req_be    = 4'hF;
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        checkOutput("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("stall_rdata", rsp_rdata, exp[31:0]);
        checkOutput("stall_err", 32'(rsp_err), 32'(exp[32]));
        checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      checkOutput("rsp_valid_after_consume", 32'(rsp_valid), 32'd0);
      checkOutput("req_ready_after_consume", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    int          accepts;
    logic        exp_ready;
    logic [32:0] exp;

    reset       = 1'b1;
    req_valid   = 1'b0; req_we   = 1'b0; req_addr   = '0; req_wdata   = '0; req_be   = '0;
    rsp_ready   = 1'b0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; req_be_b = '0;
    rsp_ready_b = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("reset_req_ready", 32'(req_ready), 32'd1);

    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
    checkOutput("load_deadbeef", last_rdata, 32'hDEADBEEF);

    applyStimulus(1'b1, 32'h20, 32'h12345678, 4'hF, 0);
    applyStimulus(1'b1, 32'h20, 32'hAAAAAAAA, 4'h5, 0);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0);
    checkOutput("partial_store", last_rdata, 32'h12AA56AA);
    applyStimulus(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 0);
    checkOutput("be_zero_store", last_rdata, 32'h12AA56AA);

    applyStimulus(1'b0, 32'h13, 32'h0, 4'h0, 0);
    checkOutput("misaligned_err", 32'(last_err), 32'd1);
    applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, 0);
    checkOutput("range_err", 32'(last_err), 32'd1);
    applyStimulus(1'b1, 32'h100, 32'h55555555, 4'hF, 0);
    applyStimulus(1'b1, 32'h11, 32'h55555555, 4'hF, 0);
    applyStimulus(1'b1, 32'hFC, 32'hCAFE0063, 4'hF, 0);
    applyStimulus(1'b0, 32'hFC, 32'h0, 4'h0, 0);
    checkOutput("last_word", last_rdata, 32'hCAFE0063);

    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 5);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 0);
    checkOutput("reread_after_stall", last_rdata, 32'hDEADBEEF);

    model[2]  = 32'hCAFEF00D;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("wait_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("wait_req_ready", 32'(req_ready), 32'd0);
    reset = 1'b1;
    #2;
    checkOutput("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("postreset_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    checkOutput("postreset_rsp_valid", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b0, 32'h8, 32'h0, 4'h0, 0);
    checkOutput("store_survives_reset", last_rdata, 32'hCAFEF00D);

    req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 32'h0; req_wdata_b = 32'h0; req_be_b = 4'h0;
    rsp_ready_b = 1'b1;
    accepts     = 0;
    exp_ready   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      checkOutput("b_req_ready", 32'(req_ready_b), 32'(exp_ready));
      if (req_ready_b) begin
        accepts++;
        exp_q.push_back({1'b0, 32'h0});
      end
      @(posedge clk); #1;
      checkOutput("b_rsp_valid", 32'(rsp_valid_b), 32'(exp_ready));
      if (rsp_valid_b) begin
        exp = exp_q.pop_front();
        checkOutput("b_rsp_rdata", rsp_rdata_b, exp[31:0]);
        checkOutput("b_rsp_err", 32'(rsp_err_b), 32'(exp[32]));
      end
      exp_ready = ~exp_ready;
    end
    req_valid_b = 1'b0;
    checkOutput("b_accept_count", 32'(accepts), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
